mem_sp_arbiter: RTL and testbench
=================================

# mem_sp_arbiter

Two-requester arbiter that shares one single-port synchronous memory (`mem_sync_sp`, write-first, 1-cycle read latency) between the instruction-fetch port and the load/store port of the core. It issues at most one memory access per cycle and gives the data port fixed priority. A starvation counter guarantees fetch progress. It returns read data and write acknowledges with registered valid flags exactly one cycle after grant.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: word address width; matches the memory.
- `DATA_WIDTH`, 64: word width.
- `DATA_BYTES`, DATA_WIDTH/8: byte-enable width.
- `STARVE_MAX`, 4: consecutive lost cycles after which fetch wins; legal range ≥1.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch read request; held with stable `if_addr` until `if_gnt`.
- `if_addr` in ADDR_WIDTH: fetch word address.
- `if_gnt` out 1: fetch accepted this cycle (combinational).
- `if_rvalid` out 1: `if_rdata` valid (registered).
- `if_rdata` out DATA_WIDTH: fetch read word.
- `d_req` in 1: data request; held with stable address, data and enables until `d_gnt`.
- `d_addr` in ADDR_WIDTH: data word address.
- `d_wdata` in DATA_WIDTH: write data.
- `d_wen` in DATA_BYTES: byte write enables; all-zero means read.
- `d_gnt` out 1: data accepted this cycle (combinational).
- `d_rvalid` out 1: data response valid (registered); for reads and writes.
- `d_rdata` out DATA_WIDTH: data response word.
- `mem_addr` out ADDR_WIDTH: to memory `i_addr`.
- `mem_wdata` out DATA_WIDTH: to memory `i_wdata`.
- `mem_wen` out DATA_BYTES: to memory `i_wen`.
- `mem_rdata` in DATA_WIDTH: from memory `o_rdata`.

## Operation
- Grant decision is combinational each cycle:
  - `fetch_pri = (starve_cnt == STARVE_MAX)`.
  - If `d_req && !(fetch_pri && if_req)`, assert `d_gnt`.
  - Otherwise, if `if_req`, assert `if_gnt`.
  - Otherwise, grant nothing. `if_gnt` and `d_gnt` are never both high.
- Memory drive:
  - Data grant: `mem_addr=d_addr`, `mem_wdata=d_wdata`, `mem_wen=d_wen`.
  - Fetch grant: `mem_addr=if_addr`, `mem_wen=0`.
  - No grant: `mem_addr=0`, `mem_wdata=0`, `mem_wen=0`.
- Response tracking: registers `if_rvalid <= if_gnt` and `d_rvalid <= d_gnt`.
  - `if_rdata` and `d_rdata` connect directly to `mem_rdata`. They are meaningful only while the matching rvalid is high.
- Write response: `d_rvalid` pulses and `d_rdata` shows the merged post-write word (write-first memory).
- Responses have no backpressure; requesters must accept the rvalid cycle.
- Starvation counter `starve_cnt` is $clog2(STARVE_MAX+1) bits:
  - Increments when `if_req && !if_gnt`, saturating at STARVE_MAX.
  - Clears to 0 when `if_gnt` is high or `if_req` is low.
- Back-to-back grants are allowed every cycle. Throughput is one access per cycle, shared between the two ports.

## Timing
- Cycle N: request and grant are both combinational, and the memory samples the address/write at the edge ending N.
- Cycle N+1: the matching rvalid is high and `*_rdata = mem_rdata`. Latency is exactly 1 cycle and fixed.
- Simultaneous requests: data wins unless `starve_cnt == STARVE_MAX`. In that case fetch wins, and the counter clears on the next edge.
- Counter at saturation with no data request: fetch is granted normally and the counter clears.
- Reset values: `if_rvalid=0`, `d_rvalid=0`, `starve_cnt=0`.
- While `rst_n=0`: `if_gnt=0`, `d_gnt=0`, `mem_wen=0`; grants are gated by `rst_n`. No write reaches memory during reset.
- Reset asserted mid-operation: any response due next cycle is dropped (rvalid is cleared asynchronously). Requesters must reissue.
- First grant after reset release is possible in the first cycle with `rst_n=1`.

## Test plan
- Fetch only: `if_req=1`, `if_addr=0x010` for 3 cycles, memory preloaded `mem[0x10..]`. Required: `if_gnt=1` each cycle, `if_rvalid=1` one cycle later, `if_rdata` equal to preload; `mem_wen=0` throughout.
- Data write then read: write `d_addr=0x005`, `d_wen=0x0F`, `d_wdata=0x1122334455667788` over `mem[5]=0`. Required: next-cycle `d_rvalid=1`, `d_rdata=0x0000000055667788`. Following read of 0x005 returns the same value.
- Contention with STARVE_MAX=4: `if_req` and `d_req` held high continuously. Required grant pattern is D,D,D,D,F repeating: fetch gets 1 of every 5 cycles, never two grants in one cycle.
- Counter clear: fetch loses 3 cycles, then `if_req` drops for 1 cycle, then returns under contention. Required: 4 further data grants before the fetch grant.
- Reset mid-operation: grant data read in cycle N, assert `rst_n=0` within N+1. Required: `d_rvalid` forced 0 immediately, `mem_wen=0`, both gnt low during reset; after release the first requested access completes with 1-cycle latency.

Source files
------------

// File: rtl/mem_sp_arbiter.sv
`timescale 1ns/1ps
// Arbitrates fetch and load/store onto one single-port sync memory; data wins unless fetch has starved.
// Latency: grant is combinational, response valid exactly one cycle later; responses have no backpressure.
module mem_sp_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 64,
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,

    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [DATA_BYTES-1:0] d_wen,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_BYTES-1:0] mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          fetch_pri;

    assign fetch_pri = (starve_cnt == CW'(STARVE_MAX));

    // Grants are gated by rst_n so nothing reaches the memory while in reset.
    always_comb begin
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (rst_n) begin
            if (d_req && !(fetch_pri && if_req)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wen   = d_wen;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    // Both ports see the memory output; the matching rvalid qualifies it.
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= d_gnt;
            if (!if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (!fetch_pri) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_sp_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_sp_arbiter with a behavioural write-first single-port memory.
module tb_mem_sp_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [10:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        d_req;
    logic [10:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wen;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic [10:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wen;
    logic [63:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic load;

    always #5 clk = ~clk;

    mem_sp_arbiter #(
        .ADDR_WIDTH(11),
        .DATA_WIDTH(64),
        .DATA_BYTES(8),
        .STARVE_MAX(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wen     (d_wen),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [63:0] preload(input int i);
        if (i == 5) return 64'h0;
        return {32'hF00D_0000 | 32'(i), 32'h1000_0000 | 32'(i)};
    endfunction

    // Write-first memory: a write returns the merged word on the next cycle.
    logic [63:0] mem [0:2047];
    always @(posedge clk) begin
        logic [63:0] w;
        if (load) begin
            for (int i = 0; i < 2048; i++) mem[i] <= preload(i);
        end else begin
            w = mem[mem_addr];
            for (int b = 0; b < 8; b++)
                if (mem_wen[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr] <= w;
            mem_rdata     <= w;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies inputs just after a falling edge, then settles; registered
    // outputs seen afterwards still belong to the previous cycle's grant.
    task automatic step(input logic rv, input logic ir, input logic [10:0] ia,
                        input logic dr, input logic [10:0] da,
                        input logic [63:0] wd, input logic [7:0] we);
        @(negedge clk);
        rst_n   = rv;
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_addr  = da;
        d_wdata = wd;
        d_wen   = we;
        #1;
    endtask

    localparam logic [63:0] F10 = 64'hF00D_0010_1000_0010;
    localparam logic [63:0] F11 = 64'hF00D_0011_1000_0011;
    localparam logic [63:0] D20 = 64'hF00D_0020_1000_0020;
    localparam logic [63:0] W5  = 64'h0000_0000_5566_7788;

    logic [0:24] t_ir, t_dr, t_f, t_d;
    logic        pf, pd;

    initial begin
        rst_n = 1'b0; load = 1'b1;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_addr = '0; d_wdata = '0; d_wen = '0;
        @(negedge clk);
        load = 1'b0;

        // Requests during reset must not be granted or write memory.
        step(1'b0, 1'b1, 11'h010, 1'b1, 11'h005, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        chk("rst_if_rvalid", if_rvalid, 1'b0);
        chk("rst_d_rvalid",  d_rvalid,  1'b0);
        chk("rst_if_gnt",    if_gnt,    1'b0);
        chk("rst_d_gnt",     d_gnt,     1'b0);
        chk("rst_mem_wen",   mem_wen,   8'h00);
        step(1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 64'h0, 8'h00);

        // Fetch only, first grant in the first cycle out of reset.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 11'h010, 1'b0, 11'h000, 64'h0, 8'h00);
            chk("fo_if_gnt",   if_gnt,   1'b1);
            chk("fo_d_gnt",    d_gnt,    1'b0);
            chk("fo_mem_addr", mem_addr, 11'h010);
            chk("fo_mem_wen",  mem_wen,  8'h00);
            chk("fo_if_rvalid", if_rvalid, (k > 0) ? 1'b1 : 1'b0);
            if (k > 0) chk("fo_if_rdata", if_rdata, F10);
        end
        step(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 64'h0, 8'h00);
        chk("fo_last_rvalid", if_rvalid, 1'b1);
        chk("fo_last_rdata",  if_rdata,  F10);
        chk("idle_if_gnt",    if_gnt,    1'b0);
        chk("idle_mem_addr",  mem_addr,  11'h000);

        // Partial write then read-back.
        step(1'b1, 1'b0, 11'h000, 1'b1, 11'h005, 64'h1122_3344_5566_7788, 8'h0F);
        chk("idle_if_rvalid", if_rvalid, 1'b0);
        chk("wr_d_gnt",     d_gnt,     1'b1);
        chk("wr_mem_addr",  mem_addr,  11'h005);
        chk("wr_mem_wen",   mem_wen,   8'h0F);
        chk("wr_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
        step(1'b1, 1'b0, 11'h000, 1'b1, 11'h005, 64'h0, 8'h00);
        chk("wr_d_rvalid", d_rvalid, 1'b1);
        chk("wr_d_rdata",  d_rdata,  W5);
        chk("rd_d_gnt",    d_gnt,    1'b1);
        chk("rd_mem_wen",  mem_wen,  8'h00);
        step(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 64'h0, 8'h00);
        chk("rd_d_rvalid", d_rvalid, 1'b1);
        chk("rd_d_rdata",  d_rdata,  W5);

        // Contention, counter clear on dropped fetch, and saturation without data.
        t_ir = 25'b1111111111_111011111_111111;
        t_dr = 25'b1111111111_111111111_111101;
        t_f  = 25'b0000100001_000000001_000010;
        t_d  = 25'b1111011110_111111110_111101;
        pf = 1'b0; pd = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step(1'b1, t_ir[k], 11'h011, t_dr[k], 11'h020, 64'h0, 8'h00);
            chk($sformatf("arb_if_gnt[%0d]", k), if_gnt, t_f[k]);
            chk($sformatf("arb_d_gnt[%0d]", k),  d_gnt,  t_d[k]);
            chk($sformatf("arb_if_rvalid[%0d]", k), if_rvalid, pf);
            chk($sformatf("arb_d_rvalid[%0d]", k),  d_rvalid,  pd);
            if (pf) chk($sformatf("arb_if_rdata[%0d]", k), if_rdata, F11);
            if (pd) chk($sformatf("arb_d_rdata[%0d]", k),  d_rdata,  D20);
            pf = t_f[k];
            pd = t_d[k];
        end

        // Reset lands while a data read response is due.
        step(1'b1, 1'b0, 11'h000, 1'b1, 11'h020, 64'h0, 8'h00);
        chk("mid_d_gnt", d_gnt, 1'b1);
        @(posedge clk);
        #2;
        d_wen = 8'hFF;
        rst_n = 1'b0;
        #1;
        chk("mid_d_rvalid", d_rvalid, 1'b0);
        chk("mid_d_gnt_rst", d_gnt, 1'b0);
        chk("mid_if_gnt_rst", if_gnt, 1'b0);
        chk("mid_mem_wen", mem_wen, 8'h00);
        step(1'b0, 1'b1, 11'h010, 1'b1, 11'h005, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        chk("mid_d_rvalid_hold", d_rvalid, 1'b0);
        chk("mid_mem_wen_hold",  mem_wen,  8'h00);
        step(1'b1, 1'b0, 11'h000, 1'b1, 11'h005, 64'h0, 8'h00);
        chk("post_d_gnt", d_gnt, 1'b1);
        step(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 64'h0, 8'h00);
        chk("post_d_rvalid", d_rvalid, 1'b1);
        chk("post_d_rdata",  d_rdata,  W5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
